// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD target counter.
// Defines the BCD digit type, the largest legal digit value,
// the counter FSM states and a digit validity check.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  // True when the nibble is a legal decimal digit (0..9).
  function automatic logic is_bcd(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit with synchronous clear and chained carry.
// Ports: clk, reset, inc (count enable), clear (force to 0), carry_in,
//        digit (registered value), digit_next (value after this edge), carry_out.
module bcd_digit_counter
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clear,
  input  logic       carry_in,
  output logic [3:0] digit,
  output logic [3:0] digit_next,
  output logic       carry_out
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clear) begin
      digit_d = 4'd0;
    end else if (inc && carry_in) begin
      digit_d = (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  // Carry ripples only through digits sitting at 9; gated by inc at the top.
  assign carry_out  = carry_in && (digit_q == BCD_MAX);
  assign digit      = digit_q;
  assign digit_next = digit_d;

endmodule

// File: rtl/bcd_target_counter.sv
// N-digit BCD up-counter with run-time loadable target and registered match.
// Ports: clk, reset, en (tick), mode (0 one-shot / 1 periodic), clear, load,
//        target_in; outputs count, match, flag, halted, load_err.
module bcd_target_counter
  import bcd_pkg::*;
#(
  parameter int                  DIGITS = 2,
  parameter logic [4*DIGITS-1:0] TARGET = 8'h32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   target_in,
  output logic [4*DIGITS-1:0]   count,
  output logic                  match,
  output logic                  flag,
  output logic                  halted,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  state_t         state_q, state_d;
  logic [W-1:0]   target_q, target_d;
  logic           match_q, match_d;
  logic           flag_q, flag_d;
  logic           load_err_q, load_err_d;

  logic [DIGITS:0] carry;
  logic [W-1:0]    next_count;
  logic            inc;
  logic            restart;
  logic            target_ok;

  assign inc      = en && (state_q == RUN);
  assign carry[0] = 1'b1;

  // All digits return to zero on clear, on a periodic hit of the target,
  // and on the all-9s rollover (carry out of the most significant digit).
  assign restart = clear || (inc && ((mode && (count == target_q)) || carry[DIGITS]));

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_counter u_digit (
      .clk        (clk),
      .reset      (reset),
      .inc        (inc),
      .clear      (restart),
      .carry_in   (carry[g]),
      .digit      (count[4*g +: 4]),
      .digit_next (next_count[4*g +: 4]),
      .carry_out  (carry[g+1])
    );
  end

  always_comb begin
    target_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd(target_in[4*i +: 4])) begin
        target_ok = 1'b0;
      end
    end
  end

  // Comparison uses target_q, so a same-cycle load only affects later cycles.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    flag_d     = flag_q;
    load_err_d = 1'b0;
    match_d    = inc && !clear && (next_count == target_q);

    if (load) begin
      if (target_ok) begin
        target_d = target_in;
      end else begin
        load_err_d = 1'b1;
      end
    end

    if (clear) begin
      state_d = RUN;
      flag_d  = 1'b0;
    end else if (match_d) begin
      flag_d = 1'b1;
      if (!mode) begin
        state_d = HALT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      target_q   <= TARGET;
      match_q    <= 1'b0;
      flag_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      match_q    <= match_d;
      flag_q     <= flag_d;
      load_err_q <= load_err_d;
    end
  end

  assign match    = match_q;
  assign flag     = flag_q;
  assign halted   = (state_q == HALT);
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_target_counter.sv
// Scoreboard bench for bcd_target_counter: the driver steps an integer-level
// reference model and queues expected outputs; a monitor pops and compares
// them one cycle later, after each rising edge.
module tb_bcd_target_counter;

  localparam int          DIGITS = 2;
  localparam int          W      = 4 * DIGITS;
  localparam int          MOD    = 100;
  localparam logic [W-1:0] TGT   = 8'h32;

  logic         clk = 1'b0;
  logic         reset, en, mode, clear, load;
  logic [W-1:0] target_in;
  logic [W-1:0] count;
  logic         match, flag, halted, load_err;

  always #5 clk = ~clk;

  bcd_target_counter #(.DIGITS(DIGITS), .TARGET(TGT)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .clear     (clear),
    .load      (load),
    .target_in (target_in),
    .count     (count),
    .match     (match),
    .flag      (flag),
    .halted    (halted),
    .load_err  (load_err)
  );

  typedef struct {
    logic [W-1:0] count;
    logic         match;
    logic         flag;
    logic         halted;
    logic         load_err;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  // Reference model state, held as plain integers.
  int m_count, m_target;
  bit m_flag, m_halted;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(input logic [W-1:0] b);
    int v;
    v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic bit all_digits_ok(input logic [W-1:0] b);
    for (int i = 0; i < DIGITS; i++) if (b[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step(input bit rst, input bit e, input bit md, input bit clr,
                      input bit ld, input logic [W-1:0] tin);
    exp_t x;
    int   old_target;
    int   nc;
    @(negedge clk);
    reset = rst; en = e; mode = md; clear = clr; load = ld; target_in = tin;
    x.match = 1'b0;
    x.load_err = 1'b0;
    if (rst) begin
      m_count = 0; m_target = from_bcd(TGT); m_flag = 0; m_halted = 0;
    end else begin
      old_target = m_target;
      if (ld) begin
        if (all_digits_ok(tin)) m_target = from_bcd(tin);
        else x.load_err = 1'b1;
      end
      if (clr) begin
        m_count = 0; m_flag = 0; m_halted = 0;
      end else if (e && !m_halted) begin
        if (md && m_count == old_target) nc = 0;
        else nc = (m_count + 1) % MOD;
        m_count = nc;
        if (nc == old_target) begin
          x.match = 1'b1;
          m_flag  = 1'b1;
          if (!md) m_halted = 1'b1;
        end
      end
    end
    x.count  = to_bcd(m_count);
    x.flag   = m_flag;
    x.halted = m_halted;
    sb.push_back(x);
  endtask

  task automatic repeat_en(input int n, input bit md);
    for (int i = 0; i < n; i++) step(0, 1, md, 0, 0, '0);
  endtask

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL cyc=%0d %s: got %h expected %h", cyc, name, got, exp);
    end
  endtask

  // Monitor: one expected entry per cycle, compared after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("count",    count,               e.count);
        chk("match",    {{(W-1){1'b0}}, match},    {{(W-1){1'b0}}, e.match});
        chk("flag",     {{(W-1){1'b0}}, flag},     {{(W-1){1'b0}}, e.flag});
        chk("halted",   {{(W-1){1'b0}}, halted},   {{(W-1){1'b0}}, e.halted});
        chk("load_err", {{(W-1){1'b0}}, load_err}, {{(W-1){1'b0}}, e.load_err});
      end
    end
  end

  initial begin
    logic [W-1:0] tin;
    reset = 1; en = 0; mode = 0; clear = 0; load = 0; target_in = '0;

    // One-shot to the reset target, then en ignored in HALT, then clear.
    step(1, 0, 0, 0, 0, '0);
    step(1, 0, 0, 0, 0, '0);
    repeat_en(36, 0);
    step(0, 0, 0, 1, 0, '0);

    // Periodic with target 05.
    step(0, 0, 1, 0, 1, 8'h05);
    repeat_en(14, 1);

    // Invalid load rejected; then lower target loaded at count 15.
    step(1, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 1, 8'h3A);
    repeat_en(15, 0);
    step(0, 1, 0, 0, 1, 8'h10);
    repeat_en(100, 0);

    // clear together with en at count 31.
    step(1, 0, 0, 0, 0, '0);
    repeat_en(31, 0);
    step(0, 1, 0, 1, 0, '0);
    repeat_en(3, 0);

    // Target zero: periodic, then one-shot from clear.
    step(0, 0, 1, 0, 1, 8'h00);
    repeat_en(5, 1);
    step(0, 0, 0, 1, 0, '0);
    repeat_en(102, 0);

    // Reset while halted at 47; clear with load in the same cycle.
    step(0, 0, 0, 1, 1, 8'h47);
    repeat_en(50, 0);
    step(1, 1, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, '0);
    step(0, 1, 1, 1, 1, 8'h02);
    repeat_en(7, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < DIGITS; d++) begin
        tin[4*d +: 4] = ($urandom % 6 == 0) ? 4'($urandom % 16) : 4'($urandom % 10);
      end
      if ($urandom % 3 == 0) tin[W-1 -: 4] = 4'($urandom % 3);
      step(($urandom % 400) == 0, ($urandom % 4) != 0, ($urandom % 8) < 4,
           ($urandom % 60) == 0, ($urandom % 40) == 0, tin);
    end
    step(0, 0, 0, 0, 0, '0);

    @(posedge clk);
    #3;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bcd_target_counter.md
# bcd_target_counter

- Parametrised N-digit BCD up-counter with a runtime-loadable BCD target and registered match detection.
- Two modes:
  - one-shot: counts to the target, then halts.
  - periodic: counts modulo target+1 and pulses on every hit.
- Sits between a tick/enable source and display or alarm logic. Replaces fixed-constant digit comparators where the compare value must change at run time.

## Interface
- DIGITS, 2, number of BCD digits (1..8); digit 0 is least significant.
- TARGET, 8'h32, reset value of the target register, 4*DIGITS bits, packed BCD.
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- en  in  1  count tick; one increment per cycle when high.
- mode  in  1  0 = one-shot, 1 = periodic; sampled every cycle.
- clear  in  1  restart: count to 0, flag to 0, state to RUN.
- load  in  1  load target_in into the target register.
- target_in  in  4*DIGITS  packed BCD target candidate.
- count  out  4*DIGITS  current packed BCD count.
- match  out  1  one-cycle pulse, high in the cycle count first shows the target value.
- flag  out  1  sticky match indicator.
- halted  out  1  high in HALT state.
- load_err  out  1  one-cycle pulse, load rejected.

## Operation
- Reset values:
  - count = 0, target = TARGET, match = 0, flag = 0, load_err = 0.
  - state = RUN, halted = 0.
- States:
  - RUN: en increments count.
  - HALT: count frozen, en ignored.
  - RUN→HALT when a match occurs with mode=0.
  - HALT→RUN only on clear; reset also returns to RUN.
- Increment, per digit: digit 9 with carry-in becomes 0 and carries out. All-9s wraps to all-0s with no extra flag.
- Periodic mode: if en and count == target, next count = 0. Otherwise next count = count+1.
- Match:
  - Condition: en && RUN && next_count == target, with target taken before any same-cycle load.
  - match is registered in the same edge as count.
  - flag is set on match and held until clear or reset.
- Target 0:
  - Periodic mode: count stays 0 and match pulses on every en cycle.
  - One-shot mode: match on the 99..9 → 0 wrap.
- Load:
  - If every target_in digit ≤ 9, target updates at the edge.
  - Otherwise target is unchanged and load_err pulses one cycle.
  - Loading a target below the current count is legal. The counter runs up through all-9s, wraps, then reaches the new target.
- Priority and simultaneous events:
  - reset > clear > en.
  - clear with en: count = 0 and no match that cycle.
  - clear with load: both take effect.
  - load with en: the comparison uses the old target; the new target applies from the next cycle.
- mode change mid-run applies from the next en cycle. A mode change in HALT has no effect until clear.
- count never holds a non-BCD digit.

## Timing
- Latency: count and match update one cycle after the en edge they result from.
- load: target is usable by the comparison one cycle after load.
- clear: count reads 0 on the cycle after clear; halted drops on that same cycle.
- match, load_err: exactly one cycle wide. Back-to-back matches (periodic, target 0) give a continuously high match.
- No handshake; en may be held high indefinitely.

## Structure
- Shared package bcd_pkg:
  - typedef bcd_digit_t = logic [3:0];
  - BCD_MAX = 4'd9;
  - function is_bcd(bcd_digit_t) for load validation;
  - enum state_t {RUN, HALT}.
- Sub-module bcd_digit_counter: one digit with inc/clear/carry_in/carry_out. Instantiate DIGITS times in a generate loop, carries chained LSD→MSD.
- Top level owns: target register, comparator on next_count, FSM, flag and pulse registers.

## Test plan
- DIGITS=2, mode=0, reset, en high 32 cycles: count steps 00..32, match on cycle 32 only, halted=1 after. Further en leaves count at 32; clear gives count=00, flag=0, halted=0.
- mode=1, load target 8'h05, en held: count cycles 0,1,2,3,4,5,0,…; match high each time count=5, flag stays high.
- load target_in=8'h3A: load_err pulses one cycle, target stays 32. Then load 8'h10 while count=15: count runs to 99, wraps to 00, matches at 10.
- clear and en in the same cycle at count=31 (target 32): count=00, no match, flag unchanged-cleared.
- Target 8'h00, mode=1: match high every en cycle, count stays 00. mode=0 from clear: match only at the 99→00 wrap.
- Reset asserted mid-count at 47 in HALT: all outputs return to reset values next cycle, target returns to 32.
